count_d_reg: RTL and testbench
==============================

COUNT_D_REG -- requirements
Module: count_d_reg

Interface
REQ-001 Parameter CNT_WIDTH, default 4: counter width in bits, legal range 1-32.
REQ-002 Parameter REG_WIDTH, default 8: data register width in bits, legal range 1-64.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset of the whole block.
REQ-005 cnt_clr  input  1: synchronous counter clear, active-high.
REQ-006 cnt_load  input  1: synchronous counter load strobe, active-high.
REQ-007 cnt_load_val  input  CNT_WIDTH: value loaded into the counter when cnt_load is high.
REQ-008 cnt_en  input  1: counter increment enable, active-high.
REQ-009 count  output  CNT_WIDTH: current counter value, driven directly from a register.
REQ-010 cnt_tc  output  1: terminal count, high when count is all ones; combinational from count.
REQ-011 reg_clr  input  1: synchronous data-register clear, active-high.
REQ-012 reg_en  input  1: data-register write enable, active-high.
REQ-013 d  input  REG_WIDTH: data-register input.
REQ-014 q  output  REG_WIDTH: data-register contents, driven directly from a register.

Function
REQ-015 The counter and the data register SHALL be fully independent; no control input of one affects the other.
REQ-016 Counter priority SHALL be, highest first: rst low, then cnt_clr, then cnt_load, then cnt_en, then hold.
REQ-017 With cnt_clr high at a rising edge, count SHALL become 0, regardless of cnt_load and cnt_en.
REQ-018 With cnt_load high and cnt_clr low at a rising edge, count SHALL become cnt_load_val, regardless of cnt_en.
REQ-019 With only cnt_en high at a rising edge, count SHALL become count+1 modulo 2^CNT_WIDTH.
REQ-020 At count all ones with increment, count SHALL wrap to 0; there is no saturation and no sticky overflow flag.
REQ-021 With cnt_clr, cnt_load and cnt_en all low, count SHALL hold its value.
REQ-022 Counter latency: a control applied before edge N SHALL be visible on count immediately after edge N (one-cycle update, no extra pipeline).
REQ-023 Data-register priority SHALL be, highest first: rst low, then reg_clr, then reg_en, then hold.
REQ-024 With reg_clr high at a rising edge, q SHALL become 0, regardless of reg_en.
REQ-025 With reg_en high and reg_clr low at a rising edge, q SHALL capture d; otherwise q SHALL hold.
REQ-026 Data-register latency: d sampled at edge N SHALL appear on q immediately after edge N.
REQ-027 No output SHALL depend combinationally on any input; q and count are register outputs, and cnt_tc depends on count only.

Reset
REQ-028 While rst is low, count SHALL be 0, cnt_tc SHALL be 0 (for CNT_WIDTH>=1 with count 0), and q SHALL be 0.
REQ-029 Assertion of rst SHALL take effect immediately, without waiting for a clock edge, including mid-count or mid-write.
REQ-030 On the first rising edge after rst deasserts, the normal priority rules (REQ-016, REQ-023) SHALL apply; rst removal itself causes no state change.

Verification
REQ-031 CNT_WIDTH=2, rst pulse, then cnt_en=1 for 5 edges -> count sequence 1,2,3,0,1; cnt_tc high only while count=3.
REQ-032 count=2, cnt_load=1, cnt_load_val=1, cnt_en=1 for one edge -> count=1; same edge with cnt_clr=1 added -> count=0.
REQ-033 REG_WIDTH=23: reg_en=1, d=0x2ABCDE at one edge -> q=0x2ABCDE; next edge with reg_en=0, d=0 -> q stays 0x2ABCDE.
REQ-034 reg_en=1 and reg_clr=1 together, d=0x5 -> q=0; next edge with reg_clr=0, reg_en=1 -> q=0x5.
REQ-035 count=3 and q=0x7F, rst driven low between clock edges -> count=0 and q=0 before the next rising edge; both hold 0 while rst stays low, even with cnt_en=1 and reg_en=1.
REQ-036 Simultaneous cnt_en=1 and reg_en=1 over 4 edges with changing d -> the counter increments by 4 and q tracks d each cycle, with no cross-interaction.

Source files
------------

// File: rtl/count_d_reg.sv
// count_d_reg: an independent up-counter and a data register sharing only clock and reset.
//
// Parameters
//   CNT_WIDTH    counter width in bits (1-32)
//   REG_WIDTH    data register width in bits (1-64)
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset, clears count and q
//   cnt_clr      synchronous counter clear (highest synchronous priority)
//   cnt_load     synchronous counter load of cnt_load_val
//   cnt_load_val counter load value
//   cnt_en       counter increment enable (wraps modulo 2^CNT_WIDTH)
//   count        counter value, register output
//   cnt_tc       terminal count, high while count is all ones
//   reg_clr      synchronous data-register clear (beats reg_en)
//   reg_en       data-register write enable
//   d            data-register input
//   q            data-register contents, register output
module count_d_reg #(
   parameter int unsigned CNT_WIDTH = 4,
   parameter int unsigned REG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cnt_clr,
   input  logic                 cnt_load,
   input  logic [CNT_WIDTH-1:0] cnt_load_val,
   input  logic                 cnt_en,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 cnt_tc,
   input  logic                 reg_clr,
   input  logic                 reg_en,
   input  logic [REG_WIDTH-1:0] d,
   output logic [REG_WIDTH-1:0] q
);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [REG_WIDTH-1:0] q_q, q_d;

   // Counter next state: clear > load > increment > hold.
   always_comb begin
      count_d = count_q;
      if (cnt_clr) begin
         count_d = '0;
      end else if (cnt_load) begin
         count_d = cnt_load_val;
      end else if (cnt_en) begin
         // Natural width truncation gives the wrap from all ones to zero.
         count_d = count_q + CNT_WIDTH'(1);
      end
   end

   // Data register next state: clear > write > hold.
   always_comb begin
      q_d = q_q;
      if (reg_clr) begin
         q_d = '0;
      end else if (reg_en) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign count  = count_q;
   assign q      = q_q;
   // Depends on the registered count only, never on inputs.
   assign cnt_tc = &count_q;

endmodule

// File: tb/tb_count_d_reg.sv
module tb_count_d_reg;

   logic        clk;
   logic        rst;
   logic        cnt_clr, cnt_load, cnt_en, reg_clr, reg_en;
   logic [1:0]  cnt_load_val;
   logic [22:0] d;
   logic [1:0]  count;
   logic        cnt_tc;
   logic [22:0] q;

   // Second instance at default widths.
   logic        b_clr, b_load, b_en, b_rclr, b_ren;
   logic [3:0]  b_load_val;
   logic [7:0]  b_d;
   logic [3:0]  b_count;
   logic        b_tc;
   logic [7:0]  b_q;

   int checks = 0;
   int errors = 0;

   count_d_reg #(.CNT_WIDTH(2), .REG_WIDTH(23)) dut (
      .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .cnt_load(cnt_load),
      .cnt_load_val(cnt_load_val), .cnt_en(cnt_en), .count(count), .cnt_tc(cnt_tc),
      .reg_clr(reg_clr), .reg_en(reg_en), .d(d), .q(q)
   );

   count_d_reg dut_b (
      .clk(clk), .rst(rst), .cnt_clr(b_clr), .cnt_load(b_load),
      .cnt_load_val(b_load_val), .cnt_en(b_en), .count(b_count), .cnt_tc(b_tc),
      .reg_clr(b_rclr), .reg_en(b_ren), .d(b_d), .q(b_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        clr;
      logic        load;
      logic [1:0]  load_val;
      logic        en;
      logic        rclr;
      logic        ren;
      logic [22:0] d;
      logic [1:0]  exp_count;
      logic        exp_tc;
      logic [22:0] exp_q;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cnt_clr = 0; cnt_load = 0; cnt_load_val = 0; cnt_en = 0;
      reg_clr = 0; reg_en = 0; d = 0;
      b_clr = 0; b_load = 0; b_load_val = 0; b_en = 0; b_rclr = 0; b_ren = 0; b_d = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //         clr load val en rclr ren d          count tc q
      vecs[0]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd1, 0, 23'h0};
      vecs[1]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd2, 0, 23'h0};
      vecs[2]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd3, 1, 23'h0};
      vecs[3]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd0, 0, 23'h0};
      vecs[4]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd1, 0, 23'h0};
      vecs[5]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd2, 0, 23'h0};
      vecs[6]  = '{0, 1, 2'd1, 1, 0, 0, 23'h0,      2'd1, 0, 23'h0};
      vecs[7]  = '{0, 0, 2'd0, 1, 0, 0, 23'h0,      2'd2, 0, 23'h0};
      vecs[8]  = '{1, 1, 2'd1, 1, 0, 0, 23'h0,      2'd0, 0, 23'h0};
      vecs[9]  = '{0, 0, 2'd0, 0, 0, 1, 23'h2ABCDE, 2'd0, 0, 23'h2ABCDE};
      vecs[10] = '{0, 1, 2'd3, 0, 0, 0, 23'h0,      2'd3, 1, 23'h2ABCDE};
      vecs[11] = '{0, 0, 2'd0, 0, 0, 0, 23'h123,    2'd3, 1, 23'h2ABCDE};
      vecs[12] = '{0, 0, 2'd0, 1, 1, 1, 23'h5,      2'd0, 0, 23'h0};
      vecs[13] = '{0, 0, 2'd0, 0, 0, 1, 23'h5,      2'd0, 0, 23'h5};
      vecs[14] = '{0, 0, 2'd0, 1, 1, 0, 23'h7,      2'd1, 0, 23'h0};
      vecs[15] = '{0, 0, 2'd0, 1, 0, 1, 23'h11,     2'd2, 0, 23'h11};
      vecs[16] = '{0, 0, 2'd0, 1, 0, 1, 23'h22,     2'd3, 1, 23'h22};
      vecs[17] = '{0, 0, 2'd0, 1, 0, 1, 23'h33,     2'd0, 0, 23'h33};
      vecs[18] = '{0, 0, 2'd0, 1, 0, 1, 23'h44,     2'd1, 0, 23'h44};
      vecs[19] = '{1, 0, 2'd0, 0, 0, 1, 23'h55,     2'd0, 0, 23'h55};
      vecs[20] = '{0, 1, 2'd2, 0, 0, 0, 23'h66,     2'd2, 0, 23'h55};

      idle_inputs();
      rst = 1'b0;
      #12;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_tc", 64'(cnt_tc), 64'd0);
      chk("reset_q", 64'(q), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      // Reset removal alone causes no state change.
      tick();
      chk("post_reset_count", 64'(count), 64'd0);
      chk("post_reset_q", 64'(q), 64'd0);

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         cnt_clr = vecs[i].clr; cnt_load = vecs[i].load; cnt_load_val = vecs[i].load_val;
         cnt_en = vecs[i].en; reg_clr = vecs[i].rclr; reg_en = vecs[i].ren; d = vecs[i].d;
         tick();
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
         chk($sformatf("vec%0d_tc", i), 64'(cnt_tc), 64'(vecs[i].exp_tc));
         chk($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].exp_q));
      end

      // Asynchronous reset mid-cycle with count=3, q=0x7F.
      @(negedge clk);
      idle_inputs();
      cnt_load = 1; cnt_load_val = 2'd3; reg_en = 1; d = 23'h7F;
      tick();
      chk("pre_async_count", 64'(count), 64'd3);
      chk("pre_async_q", 64'(q), 64'h7F);
      cnt_load = 0; cnt_en = 1; reg_en = 1; d = 23'h1234;
      #2;
      rst = 1'b0;
      #1;
      chk("async_count", 64'(count), 64'd0);
      chk("async_tc", 64'(cnt_tc), 64'd0);
      chk("async_q", 64'(q), 64'd0);
      tick();
      tick();
      chk("held_count", 64'(count), 64'd0);
      chk("held_q", 64'(q), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("release_count", 64'(count), 64'd0);
      tick();
      chk("first_edge_count", 64'(count), 64'd1);
      chk("first_edge_q", 64'(q), 64'h1234);

      // Default-width instance: wrap at 15 and an 8-bit write.
      @(negedge clk);
      idle_inputs();
      b_load = 1; b_load_val = 4'd14; b_en = 1;
      tick();
      chk("b_load_count", 64'(b_count), 64'd14);
      chk("b_load_tc", 64'(b_tc), 64'd0);
      chk("b_q_idle", 64'(b_q), 64'd0);
      @(negedge clk);
      b_load = 0; b_ren = 1; b_d = 8'hA5;
      tick();
      chk("b_count_15", 64'(b_count), 64'd15);
      chk("b_tc_15", 64'(b_tc), 64'd1);
      chk("b_q_write", 64'(b_q), 64'hA5);
      @(negedge clk);
      b_ren = 0; b_d = 8'h3C;
      tick();
      chk("b_count_wrap", 64'(b_count), 64'd0);
      chk("b_tc_wrap", 64'(b_tc), 64'd0);
      chk("b_q_hold", 64'(b_q), 64'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
